// File: rtl/tb_uart_rx_monitor.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_monitor
//   Receives 8N1 UART bytes (LSB first) from an asynchronous serial line and
//   buffers them in a small FIFO exposed over a valid/ready interface. It is
//   used as a console / pass-fail sniffer on the SoC UART0 TX pad, and it is
//   written to be synthesizable so the FPGA loopback harness can reuse it.
//
// Parameters
//   CLK_DIV     sys_clk cycles per UART bit (4..65535)
//   FIFO_DEPTH  received-byte buffer entries (power of 2, 2..16)
//   CNT_W       baud counter width
//
// Ports
//   sys_clk      clock for the whole block
//   sys_rst_n    asynchronous active-low reset
//   rx_en_i      receive enable; low aborts a frame in progress
//   rxd_i        serial line, idle high, asynchronous to sys_clk
//   byte_o       FIFO head data (0 while empty)
//   byte_vld_o   FIFO non-empty
//   byte_rdy_i   consumer ready; pop when byte_vld_o & byte_rdy_i
//   fifo_cnt_o   FIFO occupancy
//   busy_o       receiver not idle
//   frame_err_o  sticky: stop bit sampled low
//   overflow_o   sticky: byte dropped because the FIFO was full
//   err_clr_i    clears both sticky flags (a same-cycle set wins)
// ----------------------------------------------------------------------------
module tb_uart_rx_monitor #(
  parameter int unsigned CLK_DIV    = 140,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          rx_en_i,
  input  logic                          rxd_i,
  output logic [7:0]                    byte_o,
  output logic                          byte_vld_o,
  input  logic                          byte_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          busy_o,
  output logic                          frame_err_o,
  output logic                          overflow_o,
  input  logic                          err_clr_i
);

  localparam int unsigned     PW      = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LD  = CNT_W'(CLK_DIV - 1);
  localparam logic [PW:0]      FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // --------------------------------------------------------------------------
  // Input synchronizer and falling-edge detector
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic rxd_s_q;
  logic prev_q;
  logic fall_edge;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      rxd_s_q <= sync1_q;
      prev_q  <= rxd_s_q;
    end
  end

  // A line that stays low after a frame is not re-detected until it has
  // been seen high again, because prev_q must be 1.
  assign fall_edge = prev_q & ~rxd_s_q;

  // --------------------------------------------------------------------------
  // Frame state machine
  // --------------------------------------------------------------------------
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             busy_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      busy_q    <= 1'b0;
    end else if ((state_q != IDLE) && !rx_en_i) begin
      // Abort: the partial byte is simply never pushed.
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_en_i && fall_edge) begin
            cnt_q   <= HALF_LD;
            state_q <= START;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!rxd_s_q) begin
              cnt_q     <= BIT_LD;
              bit_idx_q <= '0;
              state_q   <= DATA;
            end else begin
              // Start bit gone at mid-bit: treat as a glitch.
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {rxd_s_q, shift_q[7:1]};
            cnt_q   <= BIT_LD;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          // Return to IDLE in the middle of the stop bit so a following
          // start edge is never missed.
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;

  // --------------------------------------------------------------------------
  // Stop-bit sample events
  // --------------------------------------------------------------------------
  logic stop_smp;
  logic push;
  logic ferr_set;

  always_comb begin
    stop_smp = (state_q == STOP) && (cnt_q == '0) && rx_en_i;
    push     = stop_smp & rxd_s_q;
    ferr_set = stop_smp & ~rxd_s_q;
  end

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   fcnt_q;
  logic          full;
  logic          pop;
  logic          push_acc;
  logic          ovf_set;

  always_comb begin
    full     = (fcnt_q == FULL_CNT);
    pop      = byte_vld_o & byte_rdy_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_acc = push & (~full | pop);
    ovf_set  = push & full & ~pop;
  end

  always_ff @(posedge sys_clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_acc, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  assign byte_vld_o = (fcnt_q != '0);
  assign byte_o     = byte_vld_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_cnt_o = fcnt_q;

  // --------------------------------------------------------------------------
  // Sticky error flags (set has priority over clear)
  // --------------------------------------------------------------------------
  logic frame_err_q;
  logic overflow_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= ferr_set | (frame_err_q & ~err_clr_i);
      overflow_q  <= ovf_set  | (overflow_q  & ~err_clr_i);
    end
  end

  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_tb_uart_rx_monitor.sv
// ----------------------------------------------------------------------------
// Self-checking bench for tb_uart_rx_monitor (CLK_DIV=16, FIFO_DEPTH=4).
// Stimulus tasks serialise bytes onto rxd_i and push the expected bytes into
// a scoreboard queue; a negedge monitor pops and compares every byte the
// DUT hands out over valid/ready.
// ----------------------------------------------------------------------------
module tb_tb_uart_rx_monitor;

  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       rx_en_i;
  logic       rxd_i;
  logic [7:0] byte_o;
  logic       byte_vld_o;
  logic       byte_rdy_i;
  logic [2:0] fifo_cnt_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overflow_o;
  logic       err_clr_i;

  tb_uart_rx_monitor #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rx_en_i    (rx_en_i),
    .rxd_i      (rxd_i),
    .byte_o     (byte_o),
    .byte_vld_o (byte_vld_o),
    .byte_rdy_i (byte_rdy_i),
    .fifo_cnt_o (fifo_cnt_o),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .err_clr_i  (err_clr_i)
  );

  always #5 sys_clk = ~sys_clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         rise_cyc = -1;
  logic       vld_prev = 1'b0;
  logic [7:0] exp_q[$];
  bit         exp_ferr = 1'b0;
  bit         exp_ovf = 1'b0;

  always @(posedge sys_clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected byte.
  always @(negedge sys_clk) begin
    if (byte_vld_o && !vld_prev) rise_cyc = cyc;
    vld_prev = byte_vld_o;
    if (sys_rst_n && byte_vld_o && byte_rdy_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got 0x%0h expected no byte", byte_o);
      end else begin
        chk("pop_data", byte_o, exp_q.pop_front());
      end
    end
  end

  task automatic hold(input logic v);
    rxd_i = v;
    repeat (CLK_DIV) @(posedge sys_clk);
    #1;
  endtask

  // One 8N1 frame. pop_at_stop / clr_at_stop raise rdy / err_clr for exactly
  // the cycle whose closing edge is the receiver's mid-stop-bit sample.
  task automatic send(input logic [7:0] b, input bit stop_ok,
                      input bit pop_at_stop, input bit clr_at_stop);
    @(posedge sys_clk);
    #1;
    start_cyc = cyc;
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(b[i]);
    rxd_i = stop_ok;
    repeat (10) @(posedge sys_clk);
    #1;
    if (pop_at_stop) byte_rdy_i = 1'b1;
    if (clr_at_stop) err_clr_i = 1'b1;
    @(posedge sys_clk);
    #1;
    if (pop_at_stop) byte_rdy_i = 1'b0;
    if (clr_at_stop) err_clr_i = 1'b0;
    // Reference model: any pop up to this edge has already left exp_q.
    if (stop_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
    rxd_i = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_flags();
    @(posedge sys_clk);
    #1;
    err_clr_i = 1'b1;
    @(posedge sys_clk);
    #1;
    err_clr_i = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_cnt"}, fifo_cnt_o, exp_q.size());
    chk({tag, "_ferr"}, frame_err_o, exp_ferr);
    chk({tag, "_ovf"}, overflow_o, exp_ovf);
  endtask

  task automatic drain(input string tag);
    byte_rdy_i = 1'b1;
    for (int i = 0; i < 50 && byte_vld_o; i++) begin
      @(posedge sys_clk);
      #1;
    end
    chk({tag, "_drained_vld"}, byte_vld_o, 1'b0);
    chk({tag, "_drained_cnt"}, fifo_cnt_o, exp_q.size());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int d;
    sys_rst_n  = 1'b0;
    rx_en_i    = 1'b1;
    rxd_i      = 1'b1;
    byte_rdy_i = 1'b0;
    err_clr_i  = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_byte", byte_o, 8'h00);
    chk("rst_vld", byte_vld_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk_state("rst");
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;

    // Basic byte and latency.
    rise_cyc = -1;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    d = rise_cyc - start_cyc;
    total++;
    if (rise_cyc < 0 || d < 154 || d > 156) begin
      bad++;
      $display("FAIL latency: got %0d cycles expected 155+-1", d);
    end
    chk("a5_head", byte_o, 8'hA5);
    chk_state("a5");
    drain("a5");

    // Short glitch: enters START, rejected at half-bit.
    @(posedge sys_clk);
    #1;
    rxd_i = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    rxd_i = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("glitch_busy_hi", busy_o, 1'b1);
    repeat (20) @(posedge sys_clk);
    #1;
    chk("glitch_busy_lo", busy_o, 1'b0);
    chk_state("glitch");

    // Framing error, clear, then good byte.
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    chk_state("ferr");
    clr_flags();
    chk_state("ferr_clr");
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    chk_state("3c_good");

    // Set beats a simultaneous clear.
    send(8'h55, 1'b0, 1'b0, 1'b1);
    chk_state("set_wins");
    clr_flags();

    // Overflow: five bytes into four entries.
    byte_rdy_i = 1'b0;
    for (int v = 1; v <= 5; v++) send(8'(v), 1'b1, 1'b0, 1'b0);
    chk("ovf_full_cnt", fifo_cnt_o, 3'd4);
    chk_state("ovf");
    drain("ovf");
    clr_flags();
    chk_state("ovf_clr");

    // Full FIFO with a pop on the push edge: no overflow, new byte last.
    byte_rdy_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'($urandom), 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b1, 1'b0);
    chk("pp_full_cnt", fifo_cnt_o, 3'd4);
    chk_state("pushpop");
    drain("pushpop");

    // Asynchronous reset in the middle of DATA.
    byte_rdy_i = 1'b0;
    send(8'h77, 1'b1, 1'b0, 1'b0);
    @(posedge sys_clk);
    #1;
    rxd_i = 1'b0;
    repeat (40) @(posedge sys_clk);
    #1;
    chk("rstmid_busy_hi", busy_o, 1'b1);
    #3;
    sys_rst_n = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    #1;
    chk("rstmid_byte", byte_o, 8'h00);
    chk("rstmid_vld", byte_vld_o, 1'b0);
    chk("rstmid_busy", busy_o, 1'b0);
    chk_state("rstmid");
    rxd_i = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;

    // Enable dropped mid-frame.
    byte_rdy_i = 1'b1;
    @(posedge sys_clk);
    #1;
    rxd_i = 1'b0;
    repeat (60) @(posedge sys_clk);
    #1;
    chk("en_busy_hi", busy_o, 1'b1);
    rx_en_i = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("en_busy_lo", busy_o, 1'b0);
    rxd_i = 1'b1;
    repeat (5) @(posedge sys_clk);
    #1;
    rx_en_i = 1'b1;
    repeat (200) @(posedge sys_clk);
    #1;
    chk("en_idle", busy_o, 1'b0);
    chk_state("en_drop");

    // Randomized frames, stop bits and consumer readiness.
    for (int n = 0; n < 10; n++) begin
      byte_rdy_i = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      send(b, ($urandom_range(0, 5) != 0), 1'b0, 1'b0);
      repeat ($urandom_range(0, 20)) @(posedge sys_clk);
      #1;
      chk_state("rand");
    end
    drain("final");
    clr_flags();
    chk_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
